// File: rtl/battleship_pkg.sv
// Shared Battleship definitions: game phases and ship-count sizing used by the
// phase sequencer and the placement/shot datapaths.
package battleship_pkg;

  localparam int SHIP_W    = 3;
  localparam int MAX_SHIPS = 5;

  typedef enum logic [2:0] {
    DECISION,
    PLACE_PLAYER,
    PLACE_PC,
    PLAYER_TURN,
    PC_TURN,
    WIN,
    LOSE
  } game_state_t;

endpackage

// File: rtl/battleship_game_ctrl_turn_timer.sv
// Player-turn countdown: one-second tick divider plus seconds-remaining counter.
// Held at TURN_SECONDS whenever not running; load restarts both counters.
module turn_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       run,
  output logic       tick,
  output logic [3:0] seconds_left,
  output logic       expired
);

  localparam int              DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [3:0]       SEC_INIT = 4'(TURN_SECONDS);

  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_sec;

  assign tick         = run && (r_div == DIV_LAST);
  assign seconds_left = r_sec;
  // Level: countdown exhausted; the controller qualifies it with tick.
  assign expired      = (r_sec == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_sec <= SEC_INIT;
    end else if (load || !run) begin
      r_div <= '0;
      r_sec <= SEC_INIT;
    end else begin
      r_div <= tick ? '0 : r_div + 1'b1;
      if (tick && (r_sec != 4'd0)) begin
        r_sec <= r_sec - 1'b1;
      end
    end
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship phase sequencer: ship-count decision, placement enables, alternating
// timed turns and the terminal win/lose outcome.
module battleship_game_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15,
  parameter int MAX_SHIPS    = battleship_pkg::MAX_SHIPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       player_confirm_amount,
  input  logic [2:0] player_amount_ships,
  input  logic       player_ships_located,
  input  logic       pc_ships_located,
  input  logic       player_shot_done,
  input  logic       player_shot_hit,
  input  logic       pc_shot_done,
  input  logic       pc_shot_hit,
  output logic       decision,
  output logic       player_place_en,
  output logic       pc_place_en,
  output logic       player_turn,
  output logic       pc_turn,
  output logic       turn_timeout,
  output logic [2:0] amount_ships_game,
  output logic [3:0] seconds_left,
  output logic       win,
  output logic       lose
);

  import battleship_pkg::*;

  game_state_t       r_state, w_state_nx;
  logic [SHIP_W-1:0] r_amount, w_amount_nx;
  logic [SHIP_W-1:0] r_player_hits, w_player_hits_nx, w_player_hits_sum;
  logic [SHIP_W-1:0] r_pc_hits, w_pc_hits_nx, w_pc_hits_sum;
  logic              r_confirm_q;
  logic              w_confirm_fall;
  logic              w_load, w_timeout, w_tick, w_expired;
  logic              r_decision, r_player_place_en, r_pc_place_en;
  logic              r_player_turn, r_pc_turn, r_turn_timeout, r_win, r_lose;

  turn_timer #(
    .CLK_HZ       (CLK_HZ),
    .TURN_SECONDS (TURN_SECONDS)
  ) u_turn_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (w_load),
    .run          (r_state == PLAYER_TURN),
    .tick         (w_tick),
    .seconds_left (seconds_left),
    .expired      (w_expired)
  );

  assign w_confirm_fall    = r_confirm_q && !player_confirm_amount;
  assign w_player_hits_sum = r_player_hits + SHIP_W'(player_shot_hit);
  assign w_pc_hits_sum     = r_pc_hits + SHIP_W'(pc_shot_hit);

  always_comb begin
    w_state_nx       = r_state;
    w_amount_nx      = r_amount;
    w_player_hits_nx = r_player_hits;
    w_pc_hits_nx     = r_pc_hits;
    w_load           = 1'b0;
    w_timeout        = 1'b0;
    case (r_state)
      DECISION: begin
        if (w_confirm_fall && (player_amount_ships != 3'd0) &&
            (int'(player_amount_ships) <= MAX_SHIPS)) begin
          w_amount_nx = player_amount_ships;
          w_state_nx  = PLACE_PLAYER;
        end
      end
      PLACE_PLAYER: if (player_ships_located) w_state_nx = PLACE_PC;
      PLACE_PC: begin
        if (pc_ships_located) begin
          w_state_nx = PLAYER_TURN;
          w_load     = 1'b1;
        end
      end
      PLAYER_TURN: begin
        // A shot resolved on the expiry tick takes priority over the timeout.
        if (player_shot_done) begin
          w_player_hits_nx = w_player_hits_sum;
          w_state_nx       = (w_player_hits_sum == r_amount) ? WIN : PC_TURN;
        end else if (w_tick && w_expired) begin
          w_timeout  = 1'b1;
          w_state_nx = PC_TURN;
        end
      end
      PC_TURN: begin
        if (pc_shot_done) begin
          w_pc_hits_nx = w_pc_hits_sum;
          if (w_pc_hits_sum == r_amount) begin
            w_state_nx = LOSE;
          end else begin
            w_state_nx = PLAYER_TURN;
            w_load     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= DECISION;
      r_amount          <= '0;
      r_player_hits     <= '0;
      r_pc_hits         <= '0;
      r_confirm_q       <= 1'b0;
      r_decision        <= 1'b1;
      r_player_place_en <= 1'b0;
      r_pc_place_en     <= 1'b0;
      r_player_turn     <= 1'b0;
      r_pc_turn         <= 1'b0;
      r_turn_timeout    <= 1'b0;
      r_win             <= 1'b0;
      r_lose            <= 1'b0;
    end else begin
      r_state           <= w_state_nx;
      r_amount          <= w_amount_nx;
      r_player_hits     <= w_player_hits_nx;
      r_pc_hits         <= w_pc_hits_nx;
      r_confirm_q       <= player_confirm_amount;
      r_decision        <= (w_state_nx == DECISION);
      r_player_place_en <= (w_state_nx == PLACE_PLAYER);
      r_pc_place_en     <= (w_state_nx == PLACE_PC);
      r_player_turn     <= (w_state_nx == PLAYER_TURN);
      r_pc_turn         <= (w_state_nx == PC_TURN);
      r_turn_timeout    <= w_timeout;
      r_win             <= (w_state_nx == WIN);
      r_lose            <= (w_state_nx == LOSE);
    end
  end

  assign decision          = r_decision;
  assign player_place_en   = r_player_place_en;
  assign pc_place_en       = r_pc_place_en;
  assign player_turn       = r_player_turn;
  assign pc_turn           = r_pc_turn;
  assign turn_timeout      = r_turn_timeout;
  assign amount_ships_game = r_amount;
  assign win               = r_win;
  assign lose              = r_lose;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl with a short turn (CLK_HZ=4, TURN_SECONDS=2).
module tb_battleship_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       player_confirm_amount;
  logic [2:0] player_amount_ships;
  logic       player_ships_located, pc_ships_located;
  logic       player_shot_done, player_shot_hit;
  logic       pc_shot_done, pc_shot_hit;
  logic       decision, player_place_en, pc_place_en, player_turn, pc_turn;
  logic       turn_timeout, win, lose;
  logic [2:0] amount_ships_game;
  logic [3:0] seconds_left;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int sec_at5;

  battleship_game_ctrl #(
    .CLK_HZ       (4),
    .TURN_SECONDS (2),
    .MAX_SHIPS    (5)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .player_confirm_amount (player_confirm_amount),
    .player_amount_ships   (player_amount_ships),
    .player_ships_located  (player_ships_located),
    .pc_ships_located      (pc_ships_located),
    .player_shot_done      (player_shot_done),
    .player_shot_hit       (player_shot_hit),
    .pc_shot_done          (pc_shot_done),
    .pc_shot_hit           (pc_shot_hit),
    .decision              (decision),
    .player_place_en       (player_place_en),
    .pc_place_en           (pc_place_en),
    .player_turn           (player_turn),
    .pc_turn               (pc_turn),
    .turn_timeout          (turn_timeout),
    .amount_ships_game     (amount_ships_game),
    .seconds_left          (seconds_left),
    .win                   (win),
    .lose                  (lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic try_confirm(input logic [2:0] amt);
    player_amount_ships   = amt;
    player_confirm_amount = 1'b1;
    step();
    player_confirm_amount = 1'b0;
    step();
  endtask

  task automatic place();
    player_ships_located = 1'b1;
    step();
    player_ships_located = 1'b0;
    check("pc_place_en", pc_place_en, 1);
    check("player_place_en_off", player_place_en, 0);
    pc_ships_located = 1'b1;
    step();
    pc_ships_located = 1'b0;
    check("enter_player_turn", player_turn, 1);
    check("enter_secs", seconds_left, 2);
  endtask

  task automatic player_shot(input logic hit);
    player_shot_done = 1'b1;
    player_shot_hit  = hit;
    step();
    player_shot_done = 1'b0;
    player_shot_hit  = 1'b0;
  endtask

  task automatic pc_shot(input logic hit);
    pc_shot_done = 1'b1;
    pc_shot_hit  = hit;
    step();
    pc_shot_done = 1'b0;
    pc_shot_hit  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    player_confirm_amount = 1'b0;
    player_amount_ships   = 3'd0;
    player_ships_located  = 1'b0;
    pc_ships_located      = 1'b0;
    player_shot_done      = 1'b0;
    player_shot_hit       = 1'b0;
    pc_shot_done          = 1'b0;
    pc_shot_hit           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_decision", decision, 1);
    check("rst_amount", amount_ships_game, 0);
    check("rst_secs", seconds_left, 2);
    check("rst_timeout", turn_timeout, 0);
    check("rst_win", win, 0);
    check("rst_lose", lose, 0);
    rst = 1'b1;
    step();

    // Illegal counts are ignored
    try_confirm(3'd0);
    check("amt0_decision", decision, 1);
    check("amt0_amount", amount_ships_game, 0);
    try_confirm(3'd7);
    check("amt7_decision", decision, 1);
    check("amt7_amount", amount_ships_game, 0);

    // Legal count 3: confirm falling edge latches and advances
    player_amount_ships   = 3'd3;
    player_confirm_amount = 1'b1;
    step();
    check("confirm_high_still_decision", decision, 1);
    player_confirm_amount = 1'b0;
    step();
    check("amt3_amount", amount_ships_game, 3);
    check("amt3_decision", decision, 0);
    check("amt3_place_en", player_place_en, 1);

    try_confirm(3'd1);
    check("confirm_outside_amount", amount_ships_game, 3);
    check("confirm_outside_state", player_place_en, 1);

    place();

    // Timeout with no shot
    cyc = 21;
    sec_at5 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 5) sec_at5 = int'(seconds_left);
      if (turn_timeout) begin
        cyc = k;
        break;
      end
    end
    check("timeout_cycles", cyc, 12);
    check("secs_after_first_tick", sec_at5, 1);
    check("timeout_pc_turn", pc_turn, 1);
    check("timeout_player_turn_off", player_turn, 0);
    step();
    check("timeout_pulse_width", turn_timeout, 0);
    check("pc_turn_secs", seconds_left, 2);

    // Shot on the expiry cycle wins over timeout
    pc_shot(1'b0);
    check("back_to_player", player_turn, 1);
    repeat (11) step();
    check("secs_at_expiry", seconds_left, 0);
    player_shot(1'b1);
    check("expiry_shot_no_timeout", turn_timeout, 0);
    check("expiry_shot_pc_turn", pc_turn, 1);
    check("expiry_shot_no_win", win, 0);

    player_shot(1'b1);
    check("stray_shot_pc_turn", pc_turn, 1);
    check("stray_shot_no_win", win, 0);

    pc_shot(1'b0);
    player_shot(1'b1);
    check("hits2_pc_turn", pc_turn, 1);
    check("hits2_no_win", win, 0);
    pc_shot(1'b0);
    player_shot(1'b1);
    check("hits3_win", win, 1);
    check("hits3_player_turn_off", player_turn, 0);
    repeat (3) step();
    check("win_held", win, 1);

    // Single-ship game won on first hit
    do_reset();
    try_confirm(3'd1);
    check("amt1_amount", amount_ships_game, 1);
    place();
    player_shot(1'b1);
    check("amt1_win", win, 1);
    repeat (2) step();
    check("amt1_win_held", win, 1);

    // Two ships, reset mid PC_TURN, then lose
    do_reset();
    try_confirm(3'd2);
    place();
    player_shot(1'b0);
    check("c_pc_turn", pc_turn, 1);
    pc_shot(1'b1);
    check("c_player_turn", player_turn, 1);
    check("c_no_lose", lose, 0);
    player_shot(1'b0);
    check("c_pc_turn2", pc_turn, 1);
    rst = 1'b0;
    #2;
    check("async_rst_decision", decision, 1);
    check("async_rst_pc_turn", pc_turn, 0);
    check("async_rst_amount", amount_ships_game, 0);
    check("async_rst_secs", seconds_left, 2);
    step();
    rst = 1'b1;
    step();

    try_confirm(3'd2);
    place();
    player_shot(1'b0);
    pc_shot(1'b1);
    check("pc_hits_cleared", player_turn, 1);
    check("pc_hits_cleared_no_lose", lose, 0);
    player_shot(1'b0);
    pc_shot(1'b1);
    check("lose", lose, 1);
    check("lose_pc_turn_off", pc_turn, 0);
    pc_shot(1'b1);
    step();
    check("lose_held", lose, 1);
    check("lose_no_win", win, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
# battleship_game_ctrl

Top-level phase sequencer for the Battleship game. Captures the ship count chosen by the player, then enables the player and PC ship-placement datapaths in order. It alternates player and PC turns under a per-turn countdown and declares the win/lose outcome. All game-phase datapaths take their enable strobes from this block.

## Interface
Parameters:
- CLK_HZ, 50_000_000 — clock frequency; sets the one-second tick divider.
- TURN_SECONDS, 15 — player turn time limit in seconds, 1..15.
- MAX_SHIPS, 5 — largest legal ship count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- player_confirm_amount  in  1  confirm switch; a falling edge (1→0) confirms the count.
- player_amount_ships  in  3  requested ship count.
- player_ships_located  in  1  level; player placement datapath finished.
- pc_ships_located  in  1  level; PC placement datapath finished.
- player_shot_done  in  1  one-cycle pulse; player shot resolved.
- player_shot_hit  in  1  qualifies player_shot_done; shot hit a PC ship.
- pc_shot_done  in  1  one-cycle pulse; PC shot resolved.
- pc_shot_hit  in  1  qualifies pc_shot_done; shot hit a player ship.
- decision  out  1  high in DECISION.
- player_place_en  out  1  high in PLACE_PLAYER.
- pc_place_en  out  1  high in PLACE_PC.
- player_turn  out  1  high in PLAYER_TURN.
- pc_turn  out  1  high in PC_TURN.
- turn_timeout  out  1  one-cycle pulse when the player turn expires.
- amount_ships_game  out  3  latched ship count.
- seconds_left  out  4  remaining player-turn seconds.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.

## Operation
- States: DECISION, PLACE_PLAYER, PLACE_PC, PLAYER_TURN, PC_TURN, WIN, LOSE.
- Reset state and values: DECISION; amount_ships_game=0; hit counters=0; seconds_left=TURN_SECONDS; confirm history=0; all pulses 0.
- DECISION:
  - Falling edge = previous sampled confirm 1 and current 0.
  - On a falling edge with player_amount_ships in 1..MAX_SHIPS: latch the count and go to PLACE_PLAYER.
  - Counts 0 or >MAX_SHIPS are ignored; state stays DECISION.
- PLACE_PLAYER → PLACE_PC when player_ships_located=1.
- PLACE_PC → PLAYER_TURN when pc_ships_located=1. Entering PLAYER_TURN reloads the timer.
- PLAYER_TURN:
  - On player_shot_done: player_hits += player_shot_hit.
  - If the new player_hits == amount_ships_game, go to WIN. Otherwise go to PC_TURN.
  - If the timer reaches 0 on a tick with no shot that cycle: pulse turn_timeout and go to PC_TURN; the turn is forfeited.
  - Simultaneous shot_done and expiry: the shot wins; no timeout pulse.
- PC_TURN:
  - On pc_shot_done: pc_hits += pc_shot_hit.
  - If pc_hits reaches amount_ships_game, go to LOSE. Otherwise go to PLAYER_TURN and reload the timer.
- WIN/LOSE are terminal until rst.
- Hit counters are 3 bits and never exceed amount_ships_game. Done pulses outside their own turn state are ignored.
- Confirm history is sampled every cycle in every state. A confirm edge outside DECISION is ignored.

## Timing
- One-second tick: a divider counts 0..CLK_HZ-1 and asserts tick for one cycle at the terminal count. The divider is cleared on every timer reload.
- seconds_left decrements on each tick while in PLAYER_TURN. In every other state it holds TURN_SECONDS.
- Timeout fires on the tick where seconds_left==0, giving exactly TURN_SECONDS+1 ticks of play.
- All outputs are registered. Phase outputs change one cycle after the triggering input is sampled.
- Confirm latency: amount_ships_game and the PLACE_PLAYER state update on the first edge where confirm is sampled 0 after being sampled 1.
- Reset asserted mid-game returns immediately (asynchronously) to the reset values.

## Structure
- Shared package battleship_pkg: state enum game_state_t, MAX_SHIPS, and the ship-count width constant. The placement and shot datapaths reuse these.
- One sub-module: turn_timer. It holds the tick divider and the seconds_left down-counter, with inputs load and run and outputs tick, seconds_left and expired.

## Test plan
- Reset, then confirm switch 1→0 with amount=3 → amount_ships_game=3, decision falls and player_place_en rises one cycle later.
- In DECISION, confirm falling edge with amount=0, then with amount=7 → state stays DECISION and amount_ships_game=0.
- Full sequence with amount=1: player_ships_located, pc_ships_located, then player_shot_done with hit=1 → win=1 and held.
- CLK_HZ=4, TURN_SECONDS=2 in PLAYER_TURN with no shot → turn_timeout pulses after 12 cycles and state moves to PC_TURN.
- Amount=2, PC hits on two PC turns with player misses between → lose=1 after the second pc_shot_done.
- Shot pulse on the expiry cycle → no turn_timeout and hit counted. rst low mid-PC_TURN → DECISION with all counters zero.
